switch_host_bridge: RTL and testbench

- Switch-side responder for one core port: the other end of a MatCore/VecCore send/recv interface, standing in for the Switch.
- Bridges core traffic to a host/testbench stream interface through two FIFOs.
- Used for unit-level core bring-up, and as a host I/O slot on a spare switch port.

---
 rtl/switch_pkg.sv | 24 ++
 rtl/switch_word_fifo.sv | 57 +++++
 rtl/switch_host_bridge.sv | 133 +++++++++++++
 tb/tb_switch_host_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types for the switch host bridge: word payload, tagged word, handshake states.
package switch_pkg;

    localparam int unsigned WIDTH          = 16;
    localparam int unsigned CORE_SIZE      = 8;
    localparam int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE);
    localparam int unsigned ELEM_BITS      = 32;
    localparam int unsigned OUT_DEPTH      = 4;
    localparam int unsigned IN_DEPTH       = 4;

    // Each element carries the IEEE-754 single bit pattern of a shortreal, moved bit-exact.
    typedef logic [WIDTH-1:0][ELEM_BITS-1:0] switch_word_t;

    typedef struct packed {
        logic [CORE_ADDR_SIZE-1:0] core_idx;
        switch_word_t              word;
    } tagged_word_t;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/switch_word_fifo.sv
// First-word-fall-through FIFO of tagged switch words; full/empty come from the registered count.
module switch_word_fifo
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  tagged_word_t i_wdata,
    input  logic         i_pop,
    output logic         o_full_c,
    output logic         o_empty_c,
    output tagged_word_t o_head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tagged_word_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); simultaneous push+pop leaves the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/switch_host_bridge.sv
// Switch-side responder for one core port, bridging send/recv handshakes to host streams.
module switch_host_bridge
    import switch_pkg::*;
#(
    parameter int unsigned OUT_DEPTH_P = OUT_DEPTH,
    parameter int unsigned IN_DEPTH_P  = IN_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      send_ready,
    input  logic [CORE_ADDR_SIZE-1:0] send_core_idx,
    input  switch_word_t              send_data,
    output logic                      send_ok,
    input  logic                      recv_request,
    input  logic [CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic                      recv_ready,
    output switch_word_t              recv_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CORE_ADDR_SIZE-1:0] out_dest,
    output switch_word_t              out_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CORE_ADDR_SIZE-1:0] in_src,
    input  switch_word_t              in_data,
    output logic                      tag_mismatch
);

    hs_state_t    r_send_state, w_send_state_nxt;
    hs_state_t    r_recv_state, w_recv_state_nxt;
    logic         r_send_ok;
    logic         r_recv_ready;
    switch_word_t r_recv_data;
    logic         r_tag_mismatch;
    logic         w_send_accept;
    logic         w_recv_accept;
    logic         w_recv_wrong_tag;
    logic         w_out_full, w_out_empty;
    logic         w_in_full, w_in_empty;
    tagged_word_t w_out_wdata, w_out_head;
    tagged_word_t w_in_wdata, w_in_head;

    assign w_out_wdata = '{core_idx: send_core_idx, word: send_data};
    assign w_in_wdata  = '{core_idx: in_src, word: in_data};

    switch_word_fifo #(.DEPTH(OUT_DEPTH_P)) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_send_accept),
        .i_wdata   (w_out_wdata),
        .i_pop     (out_ready),
        .o_full_c  (w_out_full),
        .o_empty_c (w_out_empty),
        .o_head_c  (w_out_head)
    );

    switch_word_fifo #(.DEPTH(IN_DEPTH_P)) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (in_valid),
        .i_wdata   (w_in_wdata),
        .i_pop     (w_recv_accept),
        .o_full_c  (w_in_full),
        .o_empty_c (w_in_empty),
        .o_head_c  (w_in_head)
    );

    // Send handshake: accept into the outbound FIFO when room, then one ignore cycle.
    always_comb begin
        w_send_state_nxt = r_send_state;
        w_send_accept    = 1'b0;
        case (r_send_state)
            HS_IDLE: begin
                if (send_ready && !w_out_full) begin
                    w_send_accept    = 1'b1;
                    w_send_state_nxt = HS_ACK;
                end
            end
            HS_ACK:  w_send_state_nxt = HS_IDLE;
            default: w_send_state_nxt = HS_IDLE;
        endcase
    end

    // Recv handshake: pop only a head whose tag matches; a wrong tag stalls and flags.
    always_comb begin
        w_recv_state_nxt = r_recv_state;
        w_recv_accept    = 1'b0;
        w_recv_wrong_tag = 1'b0;
        case (r_recv_state)
            HS_IDLE: begin
                if (recv_request && !w_in_empty) begin
                    if (w_in_head.core_idx == recv_core_idx) begin
                        w_recv_accept    = 1'b1;
                        w_recv_state_nxt = HS_ACK;
                    end else begin
                        w_recv_wrong_tag = 1'b1;
                    end
                end
            end
            HS_ACK:  w_recv_state_nxt = HS_IDLE;
            default: w_recv_state_nxt = HS_IDLE;
        endcase
    end

    // State registers and registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_send_state   <= HS_IDLE;
            r_recv_state   <= HS_IDLE;
            r_send_ok      <= 1'b0;
            r_recv_ready   <= 1'b0;
            r_recv_data    <= '0;
            r_tag_mismatch <= 1'b0;
        end else begin
            r_send_state <= w_send_state_nxt;
            r_recv_state <= w_recv_state_nxt;
            r_send_ok    <= w_send_accept;
            r_recv_ready <= w_recv_accept;
            if (w_recv_accept)    r_recv_data    <= w_in_head.word;
            if (w_recv_wrong_tag) r_tag_mismatch <= 1'b1;
        end
    end

    assign send_ok      = r_send_ok;
    assign recv_ready   = r_recv_ready;
    assign recv_data    = r_recv_data;
    assign tag_mismatch = r_tag_mismatch;
    assign out_valid    = !w_out_empty;
    assign out_dest     = w_out_head.core_idx;
    assign out_data     = w_out_head.word;
    assign in_ready     = !w_in_full;

endmodule

// File: tb/tb_switch_host_bridge.sv
// Queue-based reference model of the bridge, directed scenarios and a random full-duplex run.
module tb_switch_host_bridge;
    import switch_pkg::*;

    logic                      clock;
    logic                      reset;
    logic                      send_ready;
    logic [CORE_ADDR_SIZE-1:0] send_core_idx;
    switch_word_t              send_data;
    logic                      send_ok;
    logic                      recv_request;
    logic [CORE_ADDR_SIZE-1:0] recv_core_idx;
    logic                      recv_ready;
    switch_word_t              recv_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CORE_ADDR_SIZE-1:0] out_dest;
    switch_word_t              out_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [CORE_ADDR_SIZE-1:0] in_src;
    switch_word_t              in_data;
    logic                      tag_mismatch;

    int total = 0;
    int bad   = 0;

    switch_host_bridge dut (
        .clock(clock), .reset(reset),
        .send_ready(send_ready), .send_core_idx(send_core_idx), .send_data(send_data), .send_ok(send_ok),
        .recv_request(recv_request), .recv_core_idx(recv_core_idx), .recv_ready(recv_ready), .recv_data(recv_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_data(in_data),
        .tag_mismatch(tag_mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input switch_word_t act, input switch_word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single-precision bit pattern of k/2 for small non-negative k.
    function automatic logic [31:0] half_bits(input int unsigned k);
        int unsigned p;
        logic [31:0] mant;
        if (k == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 32; b++) if (k[b]) p = b;
        mant = 32'(k << (23 - p)) & 32'h007F_FFFF;
        return (32'(126 + p) << 23) | mant;
    endfunction

    function automatic switch_word_t rand_word();
        switch_word_t w;
        for (int i = 0; i < WIDTH; i++) w[i] = $urandom;
        return w;
    endfunction

    // ---------------- reference model ----------------
    tagged_word_t m_out_q[$];
    tagged_word_t m_in_q[$];
    bit           m_send_ok, m_recv_ready, m_tag;
    switch_word_t m_recv_data;
    bit           s_acc, o_pop, i_push, r_acc, r_head_ok;

    // A request is honoured only on a cycle where no pulse from the previous accept is showing.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_out_q.delete();
            m_in_q.delete();
            m_send_ok    = 0;
            m_recv_ready = 0;
            m_tag        = 0;
            m_recv_data  = '0;
        end else begin
            s_acc     = !m_send_ok && send_ready && (m_out_q.size() < OUT_DEPTH);
            o_pop     = out_ready && (m_out_q.size() > 0);
            i_push    = in_valid && (m_in_q.size() < IN_DEPTH);
            r_head_ok = (m_in_q.size() > 0) && (m_in_q[0].core_idx == recv_core_idx);
            r_acc     = !m_recv_ready && recv_request && r_head_ok;
            if (!m_recv_ready && recv_request && m_in_q.size() > 0 && !r_head_ok) m_tag = 1;
            if (o_pop) void'(m_out_q.pop_front());
            if (s_acc) m_out_q.push_back('{core_idx: send_core_idx, word: send_data});
            if (r_acc) begin
                m_recv_data = m_in_q[0].word;
                void'(m_in_q.pop_front());
            end
            if (i_push) m_in_q.push_back('{core_idx: in_src, word: in_data});
            m_send_ok    = s_acc;
            m_recv_ready = r_acc;
        end
    end

    // Compare DUT against the model every cycle, plus pulse-spacing rules.
    bit prev_send_ok = 0, prev_recv_ready = 0;
    always @(negedge clock) begin
        chk("send_ok", send_ok, m_send_ok);
        chk("recv_ready", recv_ready, m_recv_ready);
        chk("tag_mismatch", tag_mismatch, m_tag);
        chk("out_valid", out_valid, m_out_q.size() > 0);
        chk("in_ready", in_ready, m_in_q.size() < IN_DEPTH);
        chkw("recv_data", recv_data, m_recv_data);
        if (m_out_q.size() > 0) begin
            chk("out_dest", out_dest, m_out_q[0].core_idx);
            chkw("out_data", out_data, m_out_q[0].word);
        end
        if (prev_send_ok) chk("send_ok spacing", send_ok, 0);
        if (prev_recv_ready) chk("recv_ready spacing", recv_ready, 0);
        prev_send_ok    = send_ok;
        prev_recv_ready = recv_ready;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pulse(input string nm, input bit is_send, input int max);
        bit seen;
        seen = 0;
        for (int c = 0; c < max && !seen; c++) begin
            tick();
            seen = is_send ? send_ok : recv_ready;
        end
        chk(nm, seen, 1);
    endtask

    task automatic do_send(input string nm, input int idx, input switch_word_t d);
        send_core_idx = CORE_ADDR_SIZE'(idx);
        send_data     = d;
        send_ready    = 1;
        wait_pulse(nm, 1, 4);
        send_ready    = 0;
    endtask

    switch_word_t w_exp;
    int cnt;
    int sends, recvs, pushes, pops;
    logic [CORE_ADDR_SIZE-1:0] src_q[$];

    initial begin
        reset = 0; send_ready = 0; send_core_idx = '0; send_data = '0;
        recv_request = 0; recv_core_idx = '0; out_ready = 0;
        in_valid = 0; in_src = '0; in_data = '0;
        repeat (3) tick();
        reset = 1;
        tick();

        // 1: reset while a send is being acknowledged with one word queued
        send_core_idx = 1; send_data = rand_word(); send_ready = 1;
        tick();
        chk("t1 send_ok before reset", send_ok, 1);
        chk("t1 out_valid before reset", out_valid, 1);
        reset = 0; send_ready = 0;
        #1;
        chk("t1 send_ok in reset", send_ok, 0);
        chk("t1 out_valid in reset", out_valid, 0);
        chk("t1 in_ready in reset", in_ready, 1);
        tick(); tick();
        reset = 1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin tick(); cnt += int'(send_ok); end
        chk("t1 pulses after release", cnt, 0);

        // 2: single send idx 5, element i = i*1.5
        for (int i = 0; i < WIDTH; i++) w_exp[i] = half_bits(3 * i);
        do_send("t2 send_ok", 5, w_exp);
        chk("t2 out_valid", out_valid, 1);
        tick();
        chk("t2 send_ok one cycle", send_ok, 0);
        chk("t2 out_valid next", out_valid, 1);
        chk("t2 out_dest", out_dest, 5);
        chkw("t2 out_data", out_data, w_exp);
        out_ready = 1; tick(); out_ready = 0;
        chk("t2 out_valid after pop", out_valid, 0);

        // 3: outbound full, fifth send held until one pop
        for (int k = 0; k < 4; k++) begin
            do_send("t3 send_ok", k, rand_word());
            tick();
        end
        send_core_idx = 4; send_data = rand_word(); send_ready = 1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin tick(); cnt += int'(send_ok); end
        chk("t3 fifth held", cnt, 0);
        out_ready = 1; tick(); out_ready = 0;
        chk("t3 refused on pop cycle", send_ok, 0);
        wait_pulse("t3 fifth accepted", 1, 2);
        send_ready = 0;
        for (int d = 1; d <= 4; d++) begin
            chk("t3 drain valid", out_valid, 1);
            chk("t3 drain order", out_dest, d);
            out_ready = 1; tick(); out_ready = 0;
        end
        chk("t3 drained", out_valid, 0);

        // 4: matching recv
        for (int i = 0; i < WIDTH; i++) w_exp[i] = half_bits(14);
        in_src = 2; in_data = w_exp; in_valid = 1;
        tick();
        in_valid = 0;
        recv_core_idx = 2; recv_request = 1;
        wait_pulse("t4 recv_ready", 0, 5);
        recv_request = 0;
        chkw("t4 recv_data", recv_data, w_exp);
        chk("t4 tag_mismatch", tag_mismatch, 0);
        tick();
        chk("t4 recv_ready one cycle", recv_ready, 0);
        chkw("t4 recv_data held", recv_data, w_exp);

        // 5: wrong tag stalls and sets the sticky flag
        in_src = 3; in_data = rand_word(); in_valid = 1;
        tick();
        in_valid = 0;
        recv_core_idx = 1; recv_request = 1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin tick(); cnt += int'(recv_ready); end
        chk("t5 stalled", cnt, 0);
        chk("t5 tag_mismatch", tag_mismatch, 1);
        recv_core_idx = 3;
        wait_pulse("t5 recv after retag", 0, 4);
        recv_request = 0;
        tick();
        chk("t5 flag sticky", tag_mismatch, 1);

        // 6: random full-duplex traffic, 200 words each way
        sends = 0; recvs = 0; pushes = 0; pops = 0;
        send_data = rand_word(); send_core_idx = CORE_ADDR_SIZE'($urandom_range(CORE_SIZE - 1));
        for (int cyc = 0; cyc < 6000 && !(sends == 200 && recvs == 200 && pops == 200); cyc++) begin
            if (send_ok) begin
                sends++;
                send_data     = rand_word();
                send_core_idx = CORE_ADDR_SIZE'($urandom_range(CORE_SIZE - 1));
            end
            send_ready = (sends < 200) && ($urandom_range(3) != 0);
            if (recv_ready) recvs++;
            recv_request = (recvs < pushes) && ($urandom_range(3) != 0);
            if (recvs < pushes) recv_core_idx = src_q[recvs];
            out_ready = 1'($urandom_range(1));
            if (out_ready && out_valid) pops++;
            in_src   = CORE_ADDR_SIZE'($urandom_range(CORE_SIZE - 1));
            in_data  = rand_word();
            in_valid = (pushes < 200) && ($urandom_range(1) == 1);
            if (in_valid && in_ready) begin
                src_q.push_back(in_src);
                pushes++;
            end
            tick();
        end
        send_ready = 0; recv_request = 0; out_ready = 0; in_valid = 0;
        chk("t6 sends", sends, 200);
        chk("t6 host pops", pops, 200);
        chk("t6 host pushes", pushes, 200);
        chk("t6 recvs", recvs, 200);
        tick();
        chk("t6 outbound empty", out_valid, 0);
        chk("t6 inbound not full", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
